// File: rtl/k423_dmem_arb_pkg.sv
// Types and widths for the IFU/LSU data-memory arbiter.
package k423_dmem_arb_pkg;
`include "k423_defines.svh"

  localparam int CORE_ADDR_W  = `CORE_ADDR_W;
  localparam int CORE_XLEN    = `CORE_XLEN;
  localparam int CORE_FETCH_W = `CORE_FETCH_W;

  typedef enum logic [1:0] {
    ST_IDLE = `K423_ARB_ST_IDLE,
    ST_HOLD = `K423_ARB_ST_HOLD,
    ST_WAIT = `K423_ARB_ST_WAIT
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;
endpackage

// File: rtl/k423_arb2.sv
// Two-way LSU/IFU grant: fixed LSU priority, or round-robin when
// K423_DMEM_ARB_RR_EN is defined (pointer moves on every handshake).
module k423_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_lsu,
  input  logic req_ifu,
  input  logic upd,
  input  logic upd_lsu,
  output logic gnt_lsu
);
`ifdef K423_DMEM_ARB_RR_EN
  // Resets to "IFU granted last" so the first contention goes to the LSU.
  logic last_ifu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_ifu <= 1'b1;
    else if (upd) last_ifu <= ~upd_lsu;
  end

  assign gnt_lsu = req_lsu && (!req_ifu || last_ifu);
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, req_ifu, upd, upd_lsu};
  assign gnt_lsu   = req_lsu;
`endif
endmodule

// File: rtl/k423_defines.svh
// Shared core widths and arbiter state encoding.
`ifndef K423_DEFINES_SVH
`define K423_DEFINES_SVH

`define CORE_ADDR_W      32
`define CORE_XLEN        32
`define CORE_FETCH_W     32

`define K423_ARB_ST_IDLE 2'd0
`define K423_ARB_ST_HOLD 2'd1
`define K423_ARB_ST_WAIT 2'd2

`endif

// File: rtl/k423_dmem_arb.sv
// Shares one memory port between IFU and LSU, one transaction outstanding.
// Arbitration mode selected by K423_DMEM_ARB_RR_EN (see k423_arb2).
module k423_dmem_arb
  import k423_dmem_arb_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    ifu_req_vld_i,
  output logic                    ifu_req_rdy_o,
  input  logic [CORE_ADDR_W-1:0]  ifu_req_addr_i,
  output logic                    ifu_rsp_vld_o,
  output logic [CORE_FETCH_W-1:0] ifu_rsp_rdata_o,
  input  logic                    ifu_flush_i,
  input  logic                    lsu_req_vld_i,
  output logic                    lsu_req_rdy_o,
  input  logic [CORE_ADDR_W-1:0]  lsu_req_addr_i,
  input  logic                    lsu_req_wen_i,
  input  logic [CORE_XLEN-1:0]    lsu_req_wdata_i,
  input  logic [3:0]              lsu_req_wstrb_i,
  output logic                    lsu_rsp_vld_o,
  output logic [CORE_FETCH_W-1:0] lsu_rsp_rdata_o,
  output logic                    mem_req_vld_o,
  input  logic                    mem_req_rdy_i,
  output logic [CORE_ADDR_W-1:0]  mem_req_addr_o,
  output logic                    mem_req_wen_o,
  output logic [CORE_XLEN-1:0]    mem_req_wdata_o,
  output logic [3:0]              mem_req_wstrb_o,
  input  logic                    mem_rsp_vld_i,
  input  logic [CORE_FETCH_W-1:0] mem_rsp_rdata_i
);
  arb_state_e state;
  owner_e     owner;
  logic       drop;
  logic       arb_lsu;
  logic       sel_lsu;
  logic       issue;
  logic       hs;
  logic       rsp_done;

  assign issue    = ((state == ST_IDLE) && (ifu_req_vld_i || lsu_req_vld_i)) || (state == ST_HOLD);
  assign sel_lsu  = (state == ST_HOLD) ? (owner == OWN_LSU) : arb_lsu;
  assign hs       = issue && mem_req_rdy_i;
  assign rsp_done = (state == ST_WAIT) && mem_rsp_vld_i;

  k423_arb2 u_arb2 (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .req_lsu (lsu_req_vld_i),
    .req_ifu (ifu_req_vld_i),
    .upd     (hs),
    .upd_lsu (sel_lsu),
    .gnt_lsu (arb_lsu)
  );

  always_comb begin
    mem_req_vld_o   = issue;
    mem_req_addr_o  = '0;
    mem_req_wen_o   = 1'b0;
    mem_req_wdata_o = '0;
    mem_req_wstrb_o = 4'b0000;
    if (issue) begin
      if (sel_lsu) begin
        mem_req_addr_o  = lsu_req_addr_i;
        mem_req_wen_o   = lsu_req_wen_i;
        mem_req_wdata_o = lsu_req_wdata_i;
        mem_req_wstrb_o = lsu_req_wstrb_i;
      end else begin
        mem_req_addr_o  = ifu_req_addr_i;
      end
    end
  end

  assign lsu_req_rdy_o = issue &&  sel_lsu && mem_req_rdy_i;
  assign ifu_req_rdy_o = issue && !sel_lsu && mem_req_rdy_i;

  // A flush arriving with the response itself also swallows that response.
  assign lsu_rsp_vld_o   = rsp_done && (owner == OWN_LSU);
  assign ifu_rsp_vld_o   = rsp_done && (owner == OWN_IFU) && !drop && !ifu_flush_i;
  assign lsu_rsp_rdata_o = lsu_rsp_vld_o ? mem_rsp_rdata_i : '0;
  assign ifu_rsp_rdata_o = ifu_rsp_vld_o ? mem_rsp_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      owner <= OWN_NONE;
      drop  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            owner <= sel_lsu ? OWN_LSU : OWN_IFU;
            state <= mem_req_rdy_i ? ST_WAIT : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mem_req_rdy_i) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rsp_vld_i) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
            drop  <= 1'b0;
          end else if (ifu_flush_i && (owner == OWN_IFU)) begin
            drop  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          owner <= OWN_NONE;
          drop  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_k423_dmem_arb.sv
// Directed, cycle-scripted bench for k423_dmem_arb (both arbitration modes).
module tb_k423_dmem_arb;
  logic        clk;
  logic        rst_n;
  logic        ifu_req_vld, ifu_req_rdy, ifu_flush;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_vld;
  logic [31:0] ifu_rsp_rdata;
  logic        lsu_req_vld, lsu_req_rdy, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_rsp_vld;
  logic [31:0] lsu_rsp_rdata;
  logic        mem_req_vld, mem_req_rdy, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_vld;
  logic [31:0] mem_rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  k423_dmem_arb dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .ifu_req_vld_i   (ifu_req_vld),
    .ifu_req_rdy_o   (ifu_req_rdy),
    .ifu_req_addr_i  (ifu_req_addr),
    .ifu_rsp_vld_o   (ifu_rsp_vld),
    .ifu_rsp_rdata_o (ifu_rsp_rdata),
    .ifu_flush_i     (ifu_flush),
    .lsu_req_vld_i   (lsu_req_vld),
    .lsu_req_rdy_o   (lsu_req_rdy),
    .lsu_req_addr_i  (lsu_req_addr),
    .lsu_req_wen_i   (lsu_req_wen),
    .lsu_req_wdata_i (lsu_req_wdata),
    .lsu_req_wstrb_i (lsu_req_wstrb),
    .lsu_rsp_vld_o   (lsu_rsp_vld),
    .lsu_rsp_rdata_o (lsu_rsp_rdata),
    .mem_req_vld_o   (mem_req_vld),
    .mem_req_rdy_i   (mem_req_rdy),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_wen_o   (mem_req_wen),
    .mem_req_wdata_o (mem_req_wdata),
    .mem_req_wstrb_o (mem_req_wstrb),
    .mem_rsp_vld_i   (mem_rsp_vld),
    .mem_rsp_rdata_i (mem_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [3:0] exp_lsu;

  initial begin
    rst_n = 1'b0;
    ifu_req_vld = 0; ifu_req_addr = 0; ifu_flush = 0;
    lsu_req_vld = 0; lsu_req_addr = 32'h0; lsu_req_wen = 0;
    lsu_req_wdata = 32'hFFFF_FFFF; lsu_req_wstrb = 4'hF;
    mem_req_rdy = 0; mem_rsp_vld = 0; mem_rsp_rdata = 0;

    // Reset state
    smp();
    chk("rst_outs", {mem_req_vld, ifu_req_rdy, lsu_req_rdy, ifu_rsp_vld, lsu_rsp_vld}, 5'b0);
    nxt(); rst_n = 1'b1;

    // IFU-only fetch, response two cycles after the handshake
    ifu_req_vld = 1; ifu_req_addr = 32'h100; mem_req_rdy = 1;
    smp();
    chk("t1_req_vld", mem_req_vld, 1);
    chk("t1_addr", mem_req_addr, 32'h100);
    chk("t1_rdy", {ifu_req_rdy, lsu_req_rdy}, 2'b10);
    chk("t1_ifu_zero_wr", {mem_req_wen, mem_req_wstrb, mem_req_wdata}, 37'h0);
    nxt(); ifu_req_vld = 0;
    smp();
    chk("t1_wait_vld", {mem_req_vld, ifu_rsp_vld}, 2'b00);
    nxt(); mem_rsp_vld = 1; mem_rsp_rdata = 32'h13; ifu_req_vld = 1; ifu_req_addr = 32'h104;
    smp();
    chk("t1_rsp", {ifu_rsp_vld, ifu_rsp_rdata}, {1'b1, 32'h13});
    chk("t1_no_regrant", {mem_req_vld, ifu_req_rdy}, 2'b00);
    nxt(); mem_rsp_vld = 0;
    smp();
    chk("t1_rdata_zero", ifu_rsp_rdata, 32'h0);
    chk("t1_second_issue", {mem_req_vld, ifu_req_rdy, mem_req_addr}, {2'b11, 32'h104});
    nxt(); ifu_req_vld = 0; mem_rsp_vld = 1; mem_rsp_rdata = 32'h22;
    smp();
    chk("t1_rsp2", {ifu_rsp_vld, ifu_rsp_rdata}, {1'b1, 32'h22});
    nxt(); mem_rsp_vld = 0;

    // Contention under fixed priority: LSU first, IFU after the LSU response
    lsu_req_vld = 1; lsu_req_addr = 32'h2000; lsu_req_wen = 0;
    ifu_req_vld = 1; ifu_req_addr = 32'h200;
    smp();
    chk("t2_addr", mem_req_addr, 32'h2000);
    chk("t2_rdy", {lsu_req_rdy, ifu_req_rdy}, 2'b10);
    nxt(); lsu_req_vld = 0;
    smp();
    chk("t2_wait", {mem_req_vld, ifu_req_rdy}, 2'b00);
    nxt(); mem_rsp_vld = 1; mem_rsp_rdata = 32'h55;
    smp();
    chk("t2_lsu_rsp", {lsu_rsp_vld, lsu_rsp_rdata, ifu_rsp_vld, ifu_req_rdy}, {1'b1, 32'h55, 2'b00});
    nxt(); mem_rsp_vld = 0;
    smp();
    chk("t2_ifu_issue", {ifu_req_rdy, mem_req_addr}, {1'b1, 32'h200});
    nxt(); ifu_req_vld = 0; mem_rsp_vld = 1; mem_rsp_rdata = 32'h66;
    smp();
    chk("t2_ifu_rsp", {ifu_rsp_vld, ifu_rsp_rdata}, {1'b1, 32'h66});
    nxt(); mem_rsp_vld = 0;

    // Grant locked in HOLD while LSU arrives; flush and stray rsp in HOLD ignored
    ifu_req_vld = 1; ifu_req_addr = 32'h300; mem_req_rdy = 0;
    smp();
    chk("t3_hold0", {mem_req_vld, ifu_req_rdy, mem_req_addr}, {2'b10, 32'h300});
    nxt(); lsu_req_vld = 1; lsu_req_addr = 32'h3000; lsu_req_wen = 1;
    lsu_req_wdata = 32'h0000_ABCD; lsu_req_wstrb = 4'b0011; ifu_flush = 1;
    smp();
    chk("t3_hold1", {lsu_req_rdy, ifu_req_rdy, mem_req_addr}, {2'b00, 32'h300});
    nxt(); ifu_flush = 0; mem_rsp_vld = 1; mem_rsp_rdata = 32'h99;
    smp();
    chk("t3_hold_rsp_ign", {ifu_rsp_vld, lsu_rsp_vld, mem_req_addr}, {2'b00, 32'h300});
    nxt(); mem_rsp_vld = 0; mem_req_rdy = 1;
    smp();
    chk("t3_hs", {ifu_req_rdy, lsu_req_rdy, mem_req_addr}, {2'b10, 32'h300});
    nxt(); ifu_req_vld = 0;
    smp();
    chk("t3_wait", {mem_req_vld, lsu_req_rdy}, 2'b00);
    nxt(); mem_rsp_vld = 1; mem_rsp_rdata = 32'h77;
    smp();
    chk("t3_ifu_rsp", {ifu_rsp_vld, ifu_rsp_rdata}, {1'b1, 32'h77});
    nxt(); mem_rsp_vld = 0;
    smp();
    chk("t3_wr_fields", {lsu_req_rdy, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb},
        {1'b1, 32'h3000, 1'b1, 32'h0000_ABCD, 4'b0011});
    nxt(); lsu_req_vld = 0; mem_rsp_vld = 1; mem_rsp_rdata = 32'hFFFF;
    smp();
    chk("t3_wr_rsp", {lsu_rsp_vld, ifu_rsp_vld}, 2'b10);
    nxt(); mem_rsp_vld = 0;
    smp();
    chk("t3_wr_rsp_once", lsu_rsp_vld, 0);

    // Flush while waiting drops the response; next fetch completes
    nxt(); ifu_req_vld = 1; ifu_req_addr = 32'h400;
    smp();
    chk("t4_hs", ifu_req_rdy, 1);
    nxt(); ifu_req_vld = 0; ifu_flush = 1;
    smp();
    chk("t4_flush_cyc", ifu_rsp_vld, 0);
    nxt(); ifu_flush = 0; mem_rsp_vld = 1; mem_rsp_rdata = 32'hDEAD_BEEF;
    smp();
    chk("t4_dropped", {ifu_rsp_vld, ifu_rsp_rdata}, 33'h0);
    nxt(); mem_rsp_vld = 0; ifu_req_vld = 1; ifu_req_addr = 32'h404;
    smp();
    chk("t4_refetch", {ifu_req_rdy, mem_req_addr}, {1'b1, 32'h404});
    nxt(); ifu_req_vld = 0; mem_rsp_vld = 1; mem_rsp_rdata = 32'h1234;
    smp();
    chk("t4_refetch_rsp", {ifu_rsp_vld, ifu_rsp_rdata}, {1'b1, 32'h1234});
    nxt(); mem_rsp_vld = 0; ifu_req_vld = 1; ifu_req_addr = 32'h408;
    smp();
    chk("t4_hs2", ifu_req_rdy, 1);
    nxt(); ifu_req_vld = 0; ifu_flush = 1; mem_rsp_vld = 1; mem_rsp_rdata = 32'h5678;
    smp();
    chk("t4_flush_same_cyc", ifu_rsp_vld, 0);
    nxt(); ifu_flush = 0; mem_rsp_vld = 0;

    // Reset mid-WAIT abandons the transaction; stale response ignored
    ifu_req_vld = 1; ifu_req_addr = 32'h500;
    smp();
    chk("t5_hs", ifu_req_rdy, 1);
    nxt(); ifu_req_vld = 0; rst_n = 0;
    smp();
    chk("t5_in_rst", {mem_req_vld, ifu_req_rdy, lsu_req_rdy, ifu_rsp_vld, lsu_rsp_vld}, 5'b0);
    nxt(); rst_n = 1;
    nxt(); mem_rsp_vld = 1; mem_rsp_rdata = 32'hBAD;
    smp();
    chk("t5_stale_rsp", {ifu_rsp_vld, lsu_rsp_vld}, 2'b00);
    nxt(); mem_rsp_vld = 0;

    // Both requesters valid continuously for four transactions
`ifdef K423_DMEM_ARB_RR_EN
    exp_lsu = 4'b0101;
`else
    exp_lsu = 4'b1111;
`endif
    lsu_req_vld = 1; lsu_req_addr = 32'h6000; lsu_req_wen = 0;
    ifu_req_vld = 1; ifu_req_addr = 32'h600;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("t6_grant%0d", i), {lsu_req_rdy, ifu_req_rdy}, exp_lsu[i] ? 2'b10 : 2'b01);
      chk($sformatf("t6_addr%0d", i), mem_req_addr, exp_lsu[i] ? 32'h6000 : 32'h600);
      nxt();
      smp();
      chk($sformatf("t6_wait%0d", i), mem_req_vld, 0);
      nxt(); mem_rsp_vld = 1; mem_rsp_rdata = 32'h100 + i;
      smp();
      chk($sformatf("t6_rsp%0d", i), {lsu_rsp_vld, ifu_rsp_vld}, exp_lsu[i] ? 2'b10 : 2'b01);
      nxt(); mem_rsp_vld = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/k423_dmem_arb.md
K423_DMEM_ARB -- requirements
Module: k423_dmem_arb

Interface
- REQ-001: Port clk_i, input, 1, core clock; all state updates on its rising edge.
- REQ-002: Port rst_n_i, input, 1, reset, asynchronous assert, active-low.
- REQ-003: Ports ifu_req_vld_i (in, 1), ifu_req_rdy_o (out, 1) and ifu_req_addr_i (in, CORE_ADDR_W) SHALL form the fetch request channel.
- REQ-004: Ports ifu_rsp_vld_o (out, 1), ifu_rsp_rdata_o (out, CORE_FETCH_W) and ifu_flush_i (in, 1) SHALL form the fetch response channel; ifu_flush_i discards the fetch in flight.
- REQ-005: LSU request channel ports SHALL be:
  - lsu_req_vld_i (in, 1) and lsu_req_rdy_o (out, 1);
  - lsu_req_addr_i (in, CORE_ADDR_W) and lsu_req_wen_i (in, 1);
  - lsu_req_wdata_i (in, CORE_XLEN) and lsu_req_wstrb_i (in, 4).
- REQ-006: Ports lsu_rsp_vld_o (out, 1) and lsu_rsp_rdata_o (out, CORE_FETCH_W) SHALL form the LSU response channel.
- REQ-007: Memory request ports SHALL be mem_req_vld_o (out), mem_req_rdy_i (in), mem_req_addr_o, mem_req_wen_o, mem_req_wdata_o and mem_req_wstrb_o, with widths as the LSU fields.
- REQ-008: Ports mem_rsp_vld_i (in, 1) and mem_rsp_rdata_i (in, CORE_FETCH_W) SHALL form the memory response channel.

Function
- REQ-009: The block SHALL share one memory port between IFU and LSU with at most one outstanding transaction.
- REQ-010: The FSM SHALL have states IDLE, HOLD and WAIT.
- REQ-011: In IDLE with any request valid, the arbiter SHALL pick a winner, and the block SHALL drive:
  - mem_req_vld_o=1 and mem_req_* from the winner;
  - winner rdy = mem_req_rdy_i;
  - loser rdy = 0.
- REQ-012: Default priority SHALL be LSU over IFU.
- REQ-013: On an IDLE handshake, owner SHALL latch and the FSM SHALL go to WAIT; with mem_req_rdy_i=0, grant SHALL latch and the FSM SHALL go to HOLD.
- REQ-014: In HOLD, the latched grant SHALL be kept regardless of the other requester until the handshake, then the FSM SHALL go to WAIT; requesters hold vld and payload stable once asserted.
- REQ-015: IFU requests SHALL drive mem_req_wen_o=0, mem_req_wstrb_o=4'b0000 and mem_req_wdata_o=0.
- REQ-016: In WAIT, mem_req_vld_o and both rdy SHALL be 0.
- REQ-017: On mem_rsp_vld_i in WAIT, the owner's rsp_vld SHALL pulse 1 in the same cycle with rdata=mem_rsp_rdata_i, and the FSM SHALL go to IDLE.
- REQ-018: Minimum issue interval SHALL be 2 cycles: no new grant in the response cycle.
- REQ-019: Every accepted request, writes included, SHALL get exactly one mem response; a write response SHALL pulse lsu_rsp_vld_o with rdata don't-care.
- REQ-020: ifu_flush_i while owner=IFU in WAIT SHALL set drop; that response, or one in the same cycle as the flush, SHALL be consumed with ifu_rsp_vld_o=0, then drop SHALL clear.
- REQ-021: ifu_flush_i in IDLE/HOLD SHALL have no effect; a locked IFU request is still issued.
- REQ-022: mem_rsp_vld_i in IDLE/HOLD SHALL be ignored; no rsp_vld asserted.
- REQ-023: rsp rdata outputs SHALL be 0 when the matching rsp_vld is 0.

Reset
- REQ-024: On rst_n_i low, asynchronously:
  - state SHALL be IDLE, owner none, drop 0 and rr pointer "IFU last";
  - all vld/rdy outputs SHALL be 0.
- REQ-025: Reset mid-WAIT SHALL abandon the transaction; a later stale mem_rsp_vld_i SHALL be ignored per REQ-022.

Configuration
- REQ-026: Macro K423_DMEM_ARB_RR_EN defined SHALL give round-robin: on contention, grant the requester not granted last; the pointer SHALL update on each handshake.
- REQ-027: Macro undefined SHALL give fixed LSU priority and no pointer flop.

Structure
- REQ-028: CORE_ADDR_W, CORE_XLEN, CORE_FETCH_W and the arb FSM state encoding SHALL reside in shared k423_defines.svh.
- REQ-029: The two-way grant logic, including the RR pointer, SHALL be sub-module k423_arb2.

Verification
- REQ-030: IFU only, addr 0x100, rdy=1, rsp 2 cycles later with 0x00000013: handshake cycle 0, ifu_rsp_vld_o cycle 2, rdata 0x13.
- REQ-031: Both valid, fixed priority, LSU read 0x2000: LSU granted; IFU rdy=0 until LSU rsp; IFU issued the cycle after.
- REQ-032: IFU alone, rdy=0 for 3 cycles while LSU rises in cycle 1: grant stays IFU; addr held at IFU value until the handshake.
- REQ-033: IFU in WAIT, flush pulse, rsp 0xDEADBEEF: ifu_rsp_vld_o stays 0; the next IFU fetch completes normally.
- REQ-034: RR_EN, both valid continuously, 4 transactions: grant order LSU, IFU, LSU, IFU.
- REQ-035: LSU write, wstrb 4'b0011, wdata 0x0000ABCD: mem fields match; lsu_rsp_vld_o pulses once on rsp.
